// File: rtl/hub75_pixel_driver_if.sv
// Bundle of the scan tuple, dual framebuffer read port and HUB75 panel
// drive signals around hub75_pixel_driver. The driver uses the slave
// modport; the surrounding scan/framebuffer/IO logic uses master.
interface hub75_pixel_driver_if #(
  parameter int CBITS = 5
);
  // scan tuple from the scan counter stage
  logic [5:0]         col;
  logic [5:0]         row_top;
  logic [5:0]         row_bottom;
  logic [CBITS-1:0]   pwm_level;
  // dual-read framebuffer port
  logic [11:0]        fb_addr_top;
  logic [11:0]        fb_addr_bot;
  logic [3*CBITS-1:0] fb_data_top;
  logic [3*CBITS-1:0] fb_data_bot;
  // panel side
  logic               r1;
  logic               g1;
  logic               b1;
  logic               r2;
  logic               g2;
  logic               b2;
  logic               panel_clk_en;
  logic               lat;
  logic               oe_n;
  logic [4:0]         addr_panel;
  logic               frame_done;

  modport master (
    output col, row_top, row_bottom, pwm_level, fb_data_top, fb_data_bot,
    input  fb_addr_top, fb_addr_bot, r1, g1, b1, r2, g2, b2,
           panel_clk_en, lat, oe_n, addr_panel, frame_done
  );

  modport slave (
    input  col, row_top, row_bottom, pwm_level, fb_data_top, fb_data_bot,
    output fb_addr_top, fb_addr_bot, r1, g1, b1, r2, g2, b2,
           panel_clk_en, lat, oe_n, addr_panel, frame_done
  );
endinterface

// File: rtl/hub75_pixel_driver.sv
// HUB75 pixel driver: turns the per-cycle scan tuple into framebuffer reads,
// PWM-compared colour bits, latch pulses, blanking and the panel row address.
// Three-stage pipeline: S1 address, S2 framebuffer data, S3 registered RGB.
// The latch fires one cycle after the last column leaves S3; blanking opens
// one cycle before the latch so the row switch happens with the panel dark.
module hub75_pixel_driver #(
  parameter int COLS      = 64,
  parameter int CBITS     = 5,
  parameter int BLANK_CYC = 4
) (
  input logic                 clk,
  input logic                 rst,
  hub75_pixel_driver_if.slave bus
);

  localparam logic [5:0]       LAST_COL   = 6'(COLS - 1);
  localparam logic [CBITS-1:0] MAX_LEVEL  = {CBITS{1'b1}};
  localparam int               CW         = $clog2(BLANK_CYC + 1);
  localparam logic [CW-1:0]    BLANK_LOAD = CW'(BLANK_CYC);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO   = CW'(0);

  // strict greater-than: value 0 never lights, full scale never at top level
  function automatic logic lit(input logic [CBITS-1:0] value,
                               input logic [CBITS-1:0] level);
    return (value > level);
  endfunction

  logic             s1_valid;
  logic [5:0]       s1_col;
  logic [4:0]       s1_row;
  logic [CBITS-1:0] s1_level;
  logic             s2_valid;
  logic [5:0]       s2_col;
  logic [4:0]       s2_row;
  logic [CBITS-1:0] s2_level;
  logic             s3_valid;
  logic [5:0]       s3_col;
  logic [4:0]       s3_row;
  logic [CBITS-1:0] s3_level;
  logic [CW-1:0]    blank_cnt;

  // S1: issue both framebuffer reads and carry the tuple alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_col          <= 6'd0;
      s1_row          <= 5'd0;
      s1_level        <= '0;
      bus.fb_addr_top <= 12'd0;
      bus.fb_addr_bot <= 12'd0;
    end else begin
      s1_valid        <= 1'b1;
      s1_col          <= bus.col;
      s1_row          <= bus.row_top[4:0];
      s1_level        <= bus.pwm_level;
      bus.fb_addr_top <= {bus.row_top, bus.col};
      bus.fb_addr_bot <= {bus.row_bottom, bus.col};
    end
  end

  // S2: tuple waits one cycle for the framebuffer read data
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_col   <= 6'd0;
      s2_row   <= 5'd0;
      s2_level <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_col   <= s1_col;
      s2_row   <= s1_row;
      s2_level <= s1_level;
    end
  end

  // S3: PWM compare of all six channels; RGB forced low without a valid column
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r1           <= 1'b0;
      bus.g1           <= 1'b0;
      bus.b1           <= 1'b0;
      bus.r2           <= 1'b0;
      bus.g2           <= 1'b0;
      bus.b2           <= 1'b0;
      bus.panel_clk_en <= 1'b0;
    end else if (s2_valid) begin
      bus.r1           <= lit(bus.fb_data_top[3*CBITS-1:2*CBITS], s2_level);
      bus.g1           <= lit(bus.fb_data_top[2*CBITS-1:CBITS],   s2_level);
      bus.b1           <= lit(bus.fb_data_top[CBITS-1:0],         s2_level);
      bus.r2           <= lit(bus.fb_data_bot[3*CBITS-1:2*CBITS], s2_level);
      bus.g2           <= lit(bus.fb_data_bot[2*CBITS-1:CBITS],   s2_level);
      bus.b2           <= lit(bus.fb_data_bot[CBITS-1:0],         s2_level);
      bus.panel_clk_en <= 1'b1;
    end else begin
      bus.r1           <= 1'b0;
      bus.g1           <= 1'b0;
      bus.b1           <= 1'b0;
      bus.r2           <= 1'b0;
      bus.g2           <= 1'b0;
      bus.b2           <= 1'b0;
      bus.panel_clk_en <= 1'b0;
    end
  end

  // S3 tuple bookkeeping for the latch decision
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_col   <= 6'd0;
      s3_row   <= 5'd0;
      s3_level <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_col   <= s2_col;
      s3_row   <= s2_row;
      s3_level <= s2_level;
    end
  end

  // latch the shifted row, update the panel address and flag end of frame
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.lat        <= 1'b0;
      bus.addr_panel <= 5'd0;
      bus.frame_done <= 1'b0;
    end else if (s3_valid && (s3_col == LAST_COL)) begin
      bus.lat        <= 1'b1;
      bus.addr_panel <= s3_row;
      bus.frame_done <= (s3_row == 5'd31) && (s3_level == MAX_LEVEL);
    end else begin
      bus.lat        <= 1'b0;
      bus.frame_done <= 1'b0;
    end
  end

  // blanking window: loaded one cycle ahead of the latch, oe_n held high
  // for BLANK_CYC cycles; after reset oe_n stays high until a window ends
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= CNT_ZERO;
      bus.oe_n  <= 1'b1;
    end else if (s2_valid && (s2_col == LAST_COL)) begin
      blank_cnt <= BLANK_LOAD;
      bus.oe_n  <= 1'b1;
    end else if (blank_cnt > CNT_ONE) begin
      blank_cnt <= blank_cnt - CNT_ONE;
      bus.oe_n  <= 1'b1;
    end else if (blank_cnt == CNT_ONE) begin
      blank_cnt <= CNT_ZERO;
      bus.oe_n  <= 1'b0;
    end else begin
      blank_cnt <= CNT_ZERO;
      bus.oe_n  <= bus.oe_n;
    end
  end

endmodule

// File: tb/tb_hub75_pixel_driver.sv
// Bench for hub75_pixel_driver: a table of compare vectors plus cycle-exact
// sequences for streaming, latch/blanking timing, mid-row reset and frame_done.
module tb_hub75_pixel_driver;
  localparam int CBITS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hub75_pixel_driver_if #(.CBITS(CBITS)) bus ();

  hub75_pixel_driver #(.COLS(64), .CBITS(CBITS), .BLANK_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [14:0] mem_top [0:4095];
  logic [14:0] mem_bot [0:4095];

  // framebuffer model: data one cycle after address
  always @(posedge clk) begin
    bus.fb_data_top <= mem_top[bus.fb_addr_top];
    bus.fb_data_bot <= mem_bot[bus.fb_addr_bot];
  end

  typedef struct {
    logic [14:0] top;
    logic [14:0] bot;
    logic [4:0]  lvl;
    logic [5:0]  rgb;   // {r1,g1,b1,r2,g2,b2}
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] c, input logic [5:0] r, input logic [4:0] l);
    bus.col        = c;
    bus.row_top    = r;
    bus.row_bottom = r + 6'd32;
    bus.pwm_level  = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(6'd0, 6'd0, 5'd0);
    tick();
    tick();
  endtask

  function automatic logic [5:0] rgb_now();
    return {bus.r1, bus.g1, bus.b1, bus.r2, bus.g2, bus.b2};
  endfunction

  initial begin
    int oe_low;
    logic [5:0] cc;
    logic [5:0] rr;
    logic [5:0] pc;
    logic [5:0] pr;

    vecs[0]  = '{15'h2800, 15'h0000, 5'd10, 6'b000000}; // R=10 at level 10
    vecs[1]  = '{15'h2C00, 15'h0000, 5'd10, 6'b100000}; // R=11 at level 10
    vecs[2]  = '{15'h0000, 15'h0000, 5'd0,  6'b000000}; // zero at level 0
    vecs[3]  = '{15'h0000, 15'h0000, 5'd31, 6'b000000}; // zero at level 31
    vecs[4]  = '{15'h7C00, 15'h0000, 5'd31, 6'b000000}; // R=31 at level 31
    vecs[5]  = '{15'h7C00, 15'h0000, 5'd30, 6'b100000}; // R=31 at level 30
    vecs[6]  = '{15'h7C00, 15'h001F, 5'd3,  6'b100001}; // split halves
    vecs[7]  = '{15'h00A0, 15'h0080, 5'd4,  6'b010000}; // G=5 top, G=4 bottom
    vecs[8]  = '{15'h7FFF, 15'h7FFF, 5'd0,  6'b111111}; // all full at level 0
    vecs[9]  = '{15'h0000, 15'h52B3, 5'd20, 6'b000010}; // bottom {20,21,19}
    vecs[10] = '{15'h0443, 15'h0000, 5'd2,  6'b001000}; // top {1,2,3}
    vecs[11] = '{15'h7FFF, 15'h7FFF, 5'd31, 6'b000000}; // all full at top level

    for (int i = 0; i < 4096; i++) begin
      mem_top[i] = 15'h7FFF;
      mem_bot[i] = 15'h7FFF;
    end

    // reset values
    do_reset();
    chk("rst_fb_addr_top", 0, bus.fb_addr_top, 12'd0);
    chk("rst_fb_addr_bot", 0, bus.fb_addr_bot, 12'd0);
    chk("rst_rgb", 0, rgb_now(), 6'd0);
    chk("rst_clk_en", 0, bus.panel_clk_en, 1'b0);
    chk("rst_lat", 0, bus.lat, 1'b0);
    chk("rst_oe_n", 0, bus.oe_n, 1'b1);
    chk("rst_addr_panel", 0, bus.addr_panel, 5'd0);
    chk("rst_frame_done", 0, bus.frame_done, 1'b0);

    // continuous stream, rows 5..8, full data, level 0
    oe_low = 0;
    for (int c = 0; c < 200; c++) begin
      rst = 1'b0;
      cc = 6'(c % 64);
      rr = 6'(5 + c / 64);
      drive(cc, rr, 5'd0);
      if (c > 0) begin
        pc = 6'((c - 1) % 64);
        pr = 6'(5 + (c - 1) / 64);
        chk("s_fb_addr_top", c, bus.fb_addr_top, {pr, pc});
        chk("s_fb_addr_bot", c, bus.fb_addr_bot, {pr + 6'd32, pc});
      end
      chk("s_rgb", c, rgb_now(), (c >= 3) ? 6'b111111 : 6'b000000);
      chk("s_clk_en", c, bus.panel_clk_en, (c >= 3) ? 1'b1 : 1'b0);
      chk("s_lat", c, bus.lat, (c == 67 || c == 131 || c == 195) ? 1'b1 : 1'b0);
      chk("s_oe_n", c, bus.oe_n,
          (c < 70 || (c >= 130 && c <= 133) || (c >= 194 && c <= 197)) ? 1'b1 : 1'b0);
      chk("s_addr_panel", c, bus.addr_panel,
          (c < 67) ? 5'd0 : (c < 131) ? 5'd5 : (c < 195) ? 5'd6 : 5'd7);
      chk("s_frame_done", c, bus.frame_done, 1'b0);
      if (c >= 134 && c <= 197 && bus.oe_n == 1'b0) oe_low++;
      tick();
    end
    chk("s_oe_low_per_row", 0, oe_low, 60);

    // compare vectors, one tuple held per vector
    do_reset();
    for (int i = 0; i < 12; i++) begin
      mem_top[{6'd0, 6'(i)}]  = vecs[i].top;
      mem_bot[{6'd32, 6'(i)}] = vecs[i].bot;
      drive(6'(i), 6'd0, vecs[i].lvl);
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk("vec_rgb", i, rgb_now(), vecs[i].rgb);
      chk("vec_clk_en", i, bus.panel_clk_en, 1'b1);
    end

    // reset while col 40 of row 10 is presented, restart at col 0 of row 12
    do_reset();
    for (int c = 0; c < 186; c++) begin
      rst = (c == 104 || c == 105) ? 1'b1 : 1'b0;
      if (c < 64) begin
        drive(6'(c), 6'd9, 5'd0);
      end else if (c < 106) begin
        drive(6'(c - 64), 6'd10, 5'd0);
      end else begin
        drive(6'((c - 106) % 64), 6'(12 + (c - 106) / 64), 5'd0);
      end
      chk("mr_lat", c, bus.lat, (c == 67 || c == 173) ? 1'b1 : 1'b0);
      chk("mr_addr_panel", c, bus.addr_panel,
          (c >= 67 && c <= 104) ? 5'd9 : (c >= 173) ? 5'd12 : 5'd0);
      tick();
    end

    // frame_done: row 31 at top level, then row 31 one level lower
    do_reset();
    for (int c = 0; c < 140; c++) begin
      rst = 1'b0;
      drive(6'(c % 64), 6'd31, (c < 64) ? 5'd31 : 5'd30);
      chk("fd_frame_done", c, bus.frame_done, (c == 67) ? 1'b1 : 1'b0);
      chk("fd_lat", c, bus.lat, (c == 67 || c == 131) ? 1'b1 : 1'b0);
      chk("fd_addr_panel", c, bus.addr_panel, (c >= 67) ? 5'd31 : 5'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
